// File: rtl/decoder_scan_sequencer.sv
// Round-robin select/enable driver for a 2-to-4 decoder with a blanking gap before every select change.
// Optional `DECODER_SCAN_MASK_EN`: honour the phase mask; when undefined all four phases are always scanned.
module decoder_scan_sequencer #(
  parameter int unsigned DWELL_W   = 8,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         mask,
  output logic [1:0]         A,
  output logic               E,
  output logic               busy,
  output logic               wrap
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_ACTIVE
  } state_e;

  localparam logic [3:0]         BLANK_LD = 4'(BLANK_CYC);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  state_e             state_q, state_d;
  logic [1:0]         a_q, a_d;
  logic               e_q, e_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic [3:0]         blank_cnt_q, blank_cnt_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;

  logic [3:0]         mask_eff;
  logic [1:0]         first_phase;
  logic [1:0]         next_phase;
  logic [DWELL_W-1:0] dwell_ld;

`ifdef DECODER_SCAN_MASK_EN
  assign mask_eff = mask;
`else
  logic mask_unused;
  assign mask_unused = ^mask;
  assign mask_eff    = 4'hF;
`endif

  function automatic logic [1:0] lowest_enabled(input logic [3:0] m);
    logic [1:0] r;
    r = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (m[i-1]) r = 2'(i - 1);
    end
    return r;
  endfunction

  // Search upward from the phase after cur; i == 4 lands back on cur for a single enabled phase.
  function automatic logic [1:0] next_enabled(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] idx;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = cur + 2'(i);
      if (!found && m[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign first_phase = lowest_enabled(mask_eff);
  assign next_phase  = next_enabled(a_q, mask_eff);
  assign dwell_ld    = (dwell == '0) ? DWELL_ONE : dwell;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    e_d         = e_q;
    busy_d      = busy_q;
    wrap_d      = 1'b0;
    blank_cnt_d = blank_cnt_q;
    dwell_cnt_d = dwell_cnt_q;

    if (stop) begin
      state_d     = S_IDLE;
      e_d         = 1'b0;
      busy_d      = 1'b0;
      blank_cnt_d = '0;
      dwell_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && (mask_eff != '0)) begin
            state_d     = S_BLANK;
            a_d         = first_phase;
            busy_d      = 1'b1;
            blank_cnt_d = BLANK_LD;
          end
        end
        S_BLANK: begin
          if (blank_cnt_q <= 4'd1) begin
            state_d     = S_ACTIVE;
            e_d         = 1'b1;
            blank_cnt_d = '0;
            dwell_cnt_d = dwell_ld;
          end else begin
            blank_cnt_d = blank_cnt_q - 4'd1;
          end
        end
        S_ACTIVE: begin
          if (dwell_cnt_q <= DWELL_ONE) begin
            e_d         = 1'b0;
            dwell_cnt_d = '0;
            if (mask_eff == '0) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d     = S_BLANK;
              a_d         = next_phase;
              wrap_d      = (next_phase <= a_q);
              blank_cnt_d = BLANK_LD;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q - DWELL_ONE;
          end
        end
        default: begin
          state_d     = S_IDLE;
          e_d         = 1'b0;
          busy_d      = 1'b0;
          blank_cnt_d = '0;
          dwell_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      e_q         <= 1'b0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
      blank_cnt_q <= '0;
      dwell_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      e_q         <= e_d;
      busy_q      <= busy_d;
      wrap_q      <= wrap_d;
      blank_cnt_q <= blank_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  assign A    = a_q;
  assign E    = e_q;
  assign busy = busy_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Scoreboard bench for decoder_scan_sequencer: expected {busy,wrap,E,A} per cycle queued, then compared.
module tb_decoder_scan_sequencer;

  localparam int unsigned DW    = 8;
  localparam int unsigned BLANK = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic [DW-1:0] dwell;
  logic [3:0]    mask;
  logic [1:0]    A;
  logic          E;
  logic          busy;
  logic          wrap;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  decoder_scan_sequencer #(
    .DWELL_W  (DW),
    .BLANK_CYC(BLANK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .stop (stop),
    .dwell(dwell),
    .mask (mask),
    .A    (A),
    .E    (E),
    .busy (busy),
    .wrap (wrap)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {busy,wrap,E,A}=%b expected %b at %0t", tag, got[4:0], exp[4:0], $time);
    end
  endtask

  task automatic exp_push(input logic b, input logic w, input logic e, input logic [1:0] a);
    exp_q.push_back({b, w, e, a});
  endtask

  task automatic push_phase(input logic [1:0] p, input logic w, input int unsigned nact);
    for (int unsigned b = 0; b < BLANK; b++) exp_push(1'b1, w && (b == 0), 1'b0, p);
    for (int unsigned k = 0; k < nact; k++) exp_push(1'b1, 1'b0, 1'b1, p);
  endtask

  // Enabled phases listed in ascending order; a wrap happens each time the list restarts.
  task automatic push_scan(input logic [3:0] m, input int unsigned d, input int unsigned nphase);
    int unsigned lst[$];
    int unsigned dact;
    dact = (d == 0) ? 1 : d;
    for (int unsigned i = 0; i < 4; i++) if (m[i]) lst.push_back(i);
    for (int unsigned j = 0; j < nphase; j++)
      push_phase(2'(lst[j % lst.size()]), (j > 0) && ((j % lst.size()) == 0), dact);
  endtask

  task automatic check_now(input string tag);
    logic [4:0] e;
    e = exp_q.pop_front();
    check_val(tag, {27'd0, busy, wrap, E, A}, {27'd0, e});
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      check_now(tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    dwell = 8'd3;
    mask  = 4'hF;
    #12;
    exp_push(1'b0, 1'b0, 1'b0, 2'd0);
    check_now("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) exp_push(1'b0, 1'b0, 1'b0, 2'd0);
    drain("idle");

    // Full scans with start held high throughout
    start = 1'b1;
    push_scan(4'hF, 3, 9);
    drain("scan_f");
    start = 1'b0;
    stop  = 1'b1;
    exp_push(1'b0, 1'b0, 1'b0, 2'd0);
    drain("stop_a0");
    stop = 1'b0;

    // Zero dwell behaves as one cycle
    dwell = 8'd0;
    start = 1'b1;
    push_scan(4'hF, 0, 5);
    drain("dwell0");
    start = 1'b0;
    stop  = 1'b1;
    exp_push(1'b0, 1'b0, 1'b0, 2'd0);
    drain("stop_d0");
    stop  = 1'b0;
    dwell = 8'd3;

    // Stop in the 2nd active cycle of phase 2, then restart
    start = 1'b1;
    push_phase(2'd0, 1'b0, 3);
    push_phase(2'd1, 1'b0, 3);
    push_phase(2'd2, 1'b0, 2);
    drain("pre_stop");
    start = 1'b0;
    stop  = 1'b1;
    exp_push(1'b0, 1'b0, 1'b0, 2'd2);
    drain("stop_p2");
    stop = 1'b0;
    repeat (2) exp_push(1'b0, 1'b0, 1'b0, 2'd2);
    drain("idle_p2");
    start = 1'b1;
    push_phase(2'd0, 1'b0, 3);
    push_phase(2'd1, 1'b0, 1);
    drain("restart");
    stop = 1'b1;
    repeat (2) exp_push(1'b0, 1'b0, 1'b0, 2'd1);
    drain("stop_prio");
    stop  = 1'b0;
    start = 1'b0;

    // Asynchronous reset in the middle of an active phase
    start = 1'b1;
    push_phase(2'd0, 1'b0, 3);
    push_phase(2'd1, 1'b0, 2);
    drain("pre_rst");
    rst_n = 1'b0;
    #1;
    exp_push(1'b0, 1'b0, 1'b0, 2'd0);
    check_now("async_rst");
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) exp_push(1'b0, 1'b0, 1'b0, 2'd0);
    drain("post_rst");

`ifdef DECODER_SCAN_MASK_EN
    mask  = 4'b1010;
    start = 1'b1;
    push_scan(4'b1010, 3, 5);
    drain("mask_a");
    start = 1'b0;
    stop  = 1'b1;
    exp_push(1'b0, 1'b0, 1'b0, 2'd1);
    drain("stop_ma");
    stop = 1'b0;

    mask  = 4'b0100;
    start = 1'b1;
    push_scan(4'b0100, 3, 4);
    drain("mask_4");
    start = 1'b0;
    stop  = 1'b1;
    exp_push(1'b0, 1'b0, 1'b0, 2'd2);
    drain("stop_m4");
    stop = 1'b0;

    mask  = 4'hF;
    start = 1'b1;
    push_phase(2'd0, 1'b0, 3);
    push_phase(2'd1, 1'b0, 3);
    drain("pre_m0");
    mask  = 4'h0;
    exp_push(1'b0, 1'b0, 1'b0, 2'd1);
    drain("mask_drop");

    repeat (3) exp_push(1'b0, 1'b0, 1'b0, 2'd1);
    drain("mask0_start");
    start = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_scan_sequencer.md
# decoder_scan_sequencer

Upstream driver for the 2-to-4 decoder stage. It generates the 2-bit select `A` and the enable `E` that step the decoder through its four outputs in round-robin order. Each phase has a programmable dwell time, and there is a fixed blanking gap (`E`=0) before every select change, so no decoder output is ever glitched mid-switch. Typical uses are multiplexed display digit drive and keypad row scanning.

## Interface
Parameters:
- `DWELL_W`, default 8: width of the dwell-time input and counter.
- `BLANK_CYC`, default 2: number of `E`=0 cycles before each active phase. Legal range is 1..15.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: level; begins scanning when sampled high in IDLE.
- `stop`, input, 1: level; aborts scanning in any state.
- `dwell`, input, `DWELL_W`: active cycles per phase. A value of 0 is treated as 1.
- `mask`, input, 4: phase enable; bit i=1 includes phase i in the scan.
- `A`, output, 2: decoder select, registered.
- `E`, output, 1: decoder enable, registered.
- `busy`, output, 1: high in every state other than IDLE.
- `wrap`, output, 1: one-cycle pulse when the scan rolls over to its lowest enabled phase.

## Operation
- States: IDLE, BLANK, ACTIVE.
- Reset values: state=IDLE, `A`=2'b00, `E`=0, `busy`=0, `wrap`=0, counters=0.
- IDLE to BLANK: taken when `start`=1, `stop`=0 and `mask`≠0.
  - `A` loads the lowest enabled phase index.
  - The blank counter loads `BLANK_CYC`.
- BLANK:
  - `E`=0 and `A` is held.
  - After `BLANK_CYC` cycles, go to ACTIVE.
  - `dwell` is sampled on entry to ACTIVE (0 maps to 1).
- ACTIVE:
  - `E`=1 for exactly the sampled dwell count of cycles.
  - Then go to BLANK with `A` set to the next enabled phase above the current one, searching upward and wrapping 3→0.
- `mask` is sampled only at phase selection: on IDLE exit and on each ACTIVE exit.
- `wrap`: asserted for the single cycle in which `A` updates to an index less than or equal to its previous value. With a single enabled phase, it pulses on every ACTIVE exit.
- `stop`=1 in any state:
  - Next state is IDLE, `E`=0 on the next edge.
  - `A` keeps its last value.
  - `stop` has priority over `start` and over all transitions.
- `mask` becomes 0 while running: on the next phase selection, go to IDLE with `E`=0 and no `wrap` pulse.
- `start` held high in ACTIVE or BLANK has no effect.
- `rst_n` asserted mid-scan: all outputs go to their reset values immediately, asynchronously.

## Timing
- `start` sampled at edge n: at edge n+1, `busy`=1 and `A` is valid. `E` rises at edge n+1+`BLANK_CYC`.
- Period of one phase = `BLANK_CYC` + max(`dwell`,1) cycles.
- Full scan with k enabled phases = k × (`BLANK_CYC` + dwell) cycles.
- `A` and `E` never change on the same edge while `E`=1. `A` changes only on the ACTIVE→BLANK edge, together with `E` falling.
- `wrap` is coincident with that same `A` update.

## Configuration
- `DECODER_SCAN_MASK_EN` defined: `mask` is honoured as described above.
- Undefined: `mask` is ignored and treated as 4'b1111. The port remains present but unused, and all four phases are always scanned in order 0,1,2,3.

## Test plan
- Reset, then `start`=1 with `dwell`=3, `mask`=4'hF, `BLANK_CYC`=2:
  - `A` sequence is 0,1,2,3,0 with `E` high for 3 cycles per phase.
  - Phase period is 5 cycles.
  - `wrap` pulses once per 20 cycles, coincident with `A`: 3→0.
- `dwell`=0: `E` is high for exactly 1 cycle per phase.
- `mask`=4'b1010 (macro defined): `A` alternates 1,3,1, and `wrap` pulses on each 3→1 change.
- `mask`=4'b0100 (macro defined): `A` stays at 2, `E` is high 3 of every 5 cycles, and `wrap` pulses every 5 cycles.
- `stop` asserted in the 2nd ACTIVE cycle of phase 2:
  - `E`=0 and `busy`=0 at the next edge; `A` remains 2.
  - A subsequent `start` restarts at phase 0.
- `rst_n` pulsed low mid-ACTIVE: `E`, `A`, `busy` and `wrap` go to 0 without waiting for a clock edge, and the block stays in IDLE after release.
- `mask`=0 with `start`=1: `busy` stays 0 and `E` stays 0.
